// File: rtl/axis_tx_packet_buffer.sv
// axis_tx_packet_buffer
// Store-and-forward AXI-Stream packet buffer that feeds the DCMAC TX segment
// converter. A packet becomes visible to the output only after its last beat
// has been written, so the output side never has to insert a mid-packet
// tvalid gap. Packets longer than MAX_PKT_BEATS are discarded so they cannot
// wedge the buffer.
//
// Ports
//   clk, resetn        clock; synchronous active-low reset
//   axis_in_*          AXI-Stream slave (tdata/tkeep/tlast/tvalid/tready)
//   axis_out_*         AXI-Stream master (tdata/tkeep/tlast/tvalid/tready)
//   pkt_count          complete packets stored and not yet fully read out
//   drop_count         oversize packets discarded (saturating)
module axis_tx_packet_buffer #(
  parameter int DW            = 256,
  parameter int DEPTH         = 512,
  parameter int MAX_PKT_BEATS = 64
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [DW-1:0]            axis_in_tdata,
  input  logic [DW/8-1:0]          axis_in_tkeep,
  input  logic                     axis_in_tlast,
  input  logic                     axis_in_tvalid,
  output logic                     axis_in_tready,
  output logic [DW-1:0]            axis_out_tdata,
  output logic [DW/8-1:0]          axis_out_tkeep,
  output logic                     axis_out_tlast,
  output logic                     axis_out_tvalid,
  input  logic                     axis_out_tready,
  output logic [$clog2(DEPTH):0]   pkt_count,
  output logic [15:0]              drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int KW = DW / 8;
  localparam int EW = DW + KW + 1;
  localparam int BW = $clog2(MAX_PKT_BEATS + 1);

  typedef enum logic {PASS, DROP} state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t        state, state_nxt;
  logic [PW-1:0] wptr, cptr, rptr, optr;
  logic [PW-1:0] fill;
  logic [BW-1:0] blen, blen_nxt;
  logic          in_ready, wr_en, commit, drop_evt;

  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] rd_data_p1;
  logic          vld_p1;
  logic          rd_en;
  logic [2:0]    occ;

  logic [EW-1:0] fifo_mem [2];
  logic [1:0]    fifo_cnt;
  logic          fifo_wr_idx, fifo_rd_idx;
  logic [EW-1:0] head;
  logic          pop, pop_last;

  // Space is measured against optr (beats actually consumed downstream), not
  // rptr, because up to two read-ahead beats still occupy RAM slots.
  assign fill = wptr - optr;

  always_comb begin
    state_nxt = state;
    blen_nxt  = blen;
    in_ready  = 1'b0;
    wr_en     = 1'b0;
    commit    = 1'b0;
    drop_evt  = 1'b0;
    case (state)
      PASS: begin
        in_ready = resetn && (fill < PW'(DEPTH));
        if (axis_in_tvalid && in_ready) begin
          if (blen == BW'(MAX_PKT_BEATS)) begin
            // One beat past the limit: abandon the packet and rewind.
            drop_evt = 1'b1;
            blen_nxt = '0;
            if (!axis_in_tlast) state_nxt = DROP;
          end else begin
            wr_en = 1'b1;
            if (axis_in_tlast) begin
              commit   = 1'b1;
              blen_nxt = '0;
            end else begin
              blen_nxt = blen + BW'(1);
            end
          end
        end
      end
      DROP: begin
        in_ready = resetn;
        if (axis_in_tvalid && axis_in_tlast) begin
          state_nxt = PASS;
          blen_nxt  = '0;
        end
      end
      default: state_nxt = PASS;
    endcase
  end

  assign axis_in_tready = in_ready;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= PASS;
      blen       <= '0;
      wptr       <= '0;
      cptr       <= '0;
      drop_count <= '0;
    end else begin
      state <= state_nxt;
      blen  <= blen_nxt;
      if (wr_en) wptr <= wptr + PW'(1);
      if (commit) cptr <= wptr + PW'(1);
      if (drop_evt) begin
        wptr       <= cptr;
        drop_count <= sat_inc16(drop_count);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr[AW-1:0]] <= {axis_in_tlast, axis_in_tkeep, axis_in_tdata};
  end

  // ---- p0 -> p1: RAM read, only inside the committed region ----
  assign pop      = axis_out_tvalid && axis_out_tready;
  assign pop_last = pop && axis_out_tlast;
  // FIFO occupancy after this cycle's pop, counting the read already in flight.
  assign occ      = {1'b0, fifo_cnt} + {2'b00, vld_p1} - {2'b00, pop};
  assign rd_en    = (rptr != cptr) && (occ < 3'd2);

  always_ff @(posedge clk) begin
    if (rd_en) rd_data_p1 <= mem[rptr[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      vld_p1 <= 1'b0;
      rptr   <= '0;
    end else begin
      vld_p1 <= rd_en;
      if (rd_en) rptr <= rptr + PW'(1);
    end
  end

  // ---- p1 -> p2: load the 2-entry output FIFO ----
  always_ff @(posedge clk) begin
    if (vld_p1) fifo_mem[fifo_wr_idx] <= rd_data_p1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      fifo_cnt    <= '0;
      fifo_wr_idx <= 1'b0;
      fifo_rd_idx <= 1'b0;
      optr        <= '0;
    end else begin
      fifo_cnt <= fifo_cnt + {1'b0, vld_p1} - {1'b0, pop};
      if (vld_p1) fifo_wr_idx <= ~fifo_wr_idx;
      if (pop) begin
        fifo_rd_idx <= ~fifo_rd_idx;
        optr        <= optr + PW'(1);
      end
    end
  end

  assign head            = fifo_mem[fifo_rd_idx];
  assign axis_out_tvalid = (fifo_cnt != 2'd0);
  assign axis_out_tdata  = head[DW-1:0];
  assign axis_out_tkeep  = head[DW+KW-1:DW];
  assign axis_out_tlast  = axis_out_tvalid && head[EW-1];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pkt_count <= '0;
    end else begin
      case ({commit, pop_last})
        2'b10:   pkt_count <= pkt_count + PW'(1);
        2'b01:   pkt_count <= pkt_count - PW'(1);
        default: pkt_count <= pkt_count;
      endcase
    end
  end

endmodule
